vote_tally: RTL and testbench

VOTE_TALLY -- requirements
Module: vote_tally

---
 rtl/vote_tally.sv | 178 +++++++++++++++++
 tb/tb_vote_tally.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally.sv
// Single-press vote counter with lock-out, saturation and a sequential
// winner scan that reports the highest count (lowest index on ties).
module vote_tally #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 7
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [NUM_CAND-1:0]       vote_valid,
  output logic                      vote_ack,
  output logic                      vote_reject,
  output logic [NUM_CAND*CNT_W-1:0] tally,
  output logic [CNT_W+3:0]          total,
  output logic                      sat_flag,
  output logic [3:0]                winner_idx,
  output logic                      winner_tie,
  output logic                      result_valid
);

  localparam int IW = 5;
  localparam int TW = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ARMED,
    LOCKED,
    SCAN,
    RESULT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CAND];
  logic [CNT_W-1:0]  cnt_d [NUM_CAND];
  logic [TW-1:0]     total_q, total_d;
  logic              sat_q, sat_d;
  logic              ack_q, ack_d;
  logic              rej_q, rej_d;
  logic              rv_q, rv_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]  best_q, best_d;
  logic [3:0]        bidx_q, bidx_d;
  logic              btie_q, btie_d;
  logic [3:0]        win_q, win_d;
  logic              wtie_q, wtie_d;

  logic              any_press;
  logic              one_hot;
  logic              press_sat;
  logic [CNT_W-1:0]  scan_cnt;

  // Classify the press pattern and fetch the counter under the scan index
  always_comb begin
    any_press = |vote_valid;
    one_hot   = any_press &&
                ((vote_valid & (vote_valid - NUM_CAND'(1))) == '0);
    press_sat = 1'b0;
    scan_cnt  = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_valid[i] && cnt_q[i] == CNT_MAX) press_sat = 1'b1;
      if (idx_q == IW'(i)) scan_cnt = cnt_q[i];
    end
  end

  // Next-state, counter and result computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    sat_d   = sat_q;
    ack_d   = 1'b0;
    rej_d   = 1'b0;
    rv_d    = 1'b0;
    idx_d   = idx_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    btie_d  = btie_q;
    win_d   = win_q;
    wtie_d  = wtie_q;
    unique case (state_q)
      ARMED, LOCKED: begin
        if (mode) begin
          state_d = SCAN;
          idx_d   = '0;
          best_d  = '0;
          bidx_d  = '0;
          btie_d  = 1'b0;
        end else if (state_q == LOCKED) begin
          if (!any_press) state_d = ARMED;
        end else if (any_press) begin
          state_d = LOCKED;
          if (!one_hot) begin
            rej_d = 1'b1;
          end else if (press_sat) begin
            rej_d = 1'b1;
            sat_d = 1'b1;
          end else begin
            ack_d   = 1'b1;
            total_d = total_q + TW'(1);
            for (int i = 0; i < NUM_CAND; i++) begin
              if (vote_valid[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
      end
      SCAN: begin
        if (!mode) begin
          state_d = LOCKED;
        end else if (idx_q == IW'(NUM_CAND)) begin
          state_d = RESULT;
          win_d   = bidx_q;
          wtie_d  = btie_q;
          rv_d    = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
          if (scan_cnt > best_q) begin
            best_d = scan_cnt;
            bidx_d = idx_q[3:0];
            btie_d = 1'b0;
          end else if (scan_cnt == best_q && idx_q != '0) begin
            btie_d = 1'b1;
          end
        end
      end
      RESULT: begin
        if (!mode) state_d = LOCKED;
        else rv_d = 1'b1;
      end
      default: state_d = ARMED;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARMED;
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      total_q <= '0;
      sat_q   <= 1'b0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      rv_q    <= 1'b0;
      idx_q   <= '0;
      best_q  <= '0;
      bidx_q  <= '0;
      btie_q  <= 1'b0;
      win_q   <= '0;
      wtie_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      sat_q   <= sat_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
      rv_q    <= rv_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      btie_q  <= btie_d;
      win_q   <= win_d;
      wtie_q  <= wtie_d;
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally
    assign tally[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign total        = total_q;
  assign sat_flag     = sat_q;
  assign vote_ack     = ack_q;
  assign vote_reject  = rej_q;
  assign result_valid = rv_q;
  assign winner_idx   = win_q;
  assign winner_tie   = wtie_q;

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: default build plus a CNT_W=2 build
// sharing the same stimulus for the saturation case.
module tb_vote_tally;

  logic        clock = 1'b0;
  logic        reset;
  logic        mode;
  logic [3:0]  vote_valid;

  logic        ack1, rej1, sat1, tie1, rv1;
  logic [27:0] tally1;
  logic [10:0] total1;
  logic [3:0]  win1;

  logic        ack2, rej2, sat2, tie2, rv2;
  logic [7:0]  tally2;
  logic [5:0]  total2;
  logic [3:0]  win2;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  vote_tally dut1 (
    .clock(clock), .reset(reset), .mode(mode),
    .vote_valid(vote_valid), .vote_ack(ack1), .vote_reject(rej1),
    .tally(tally1), .total(total1), .sat_flag(sat1),
    .winner_idx(win1), .winner_tie(tie1), .result_valid(rv1)
  );

  vote_tally #(.NUM_CAND(4), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .mode(mode),
    .vote_valid(vote_valid), .vote_ack(ack2), .vote_reject(rej2),
    .tally(tally2), .total(total2), .sat_flag(sat2),
    .winner_idx(win2), .winner_tie(tie2), .result_valid(rv2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] c1(input int i);
    return 32'(tally1[i*7 +: 7]);
  endfunction

  function automatic logic [31:0] c2(input int i);
    return 32'(tally2[i*2 +: 2]);
  endfunction

  task automatic press(input int i);
    vote_valid = 4'(1 << i);
    step();
    chk("press_ack", 32'(ack1), 1);
    vote_valid = 4'b0;
    step();
    chk("press_ack_drop", 32'(ack1), 0);
  endtask

  task automatic run_scan(input logic [3:0] w, input logic t);
    mode = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("scan_rv_low", 32'(rv1), 0);
    end
    step();
    chk("scan_rv_high", 32'(rv1), 1);
    chk("scan_win", 32'(win1), 32'(w));
    chk("scan_tie", 32'(tie1), 32'(t));
  endtask

  initial begin
    reset      = 1'b1;
    mode       = 1'b0;
    vote_valid = 4'b0;
    step();
    step();
    chk("rst_tally", 32'(tally1), 0);
    chk("rst_total", 32'(total1), 0);
    chk("rst_ack", 32'(ack1), 0);
    chk("rst_rej", 32'(rej1), 0);
    chk("rst_sat", 32'(sat1), 0);
    chk("rst_rv", 32'(rv1), 0);
    chk("rst_win", 32'(win1), 0);
    chk("rst_tie", 32'(tie1), 0);
    reset = 1'b0;

    vote_valid = 4'b0100;
    step();
    chk("hold_ack1", 32'(ack1), 1);
    chk("hold_cnt2", c1(2), 1);
    chk("hold_total", 32'(total1), 1);
    step();
    chk("hold_ack_off", 32'(ack1), 0);
    step();
    chk("hold_ack_off2", 32'(ack1), 0);
    chk("hold_cnt2_same", c1(2), 1);
    vote_valid = 4'b0;
    step();
    vote_valid = 4'b0100;
    step();
    chk("again_ack", 32'(ack1), 1);
    chk("again_cnt2", c1(2), 2);
    chk("again_total", 32'(total1), 2);
    vote_valid = 4'b0;
    step();
    chk("again_ack_off", 32'(ack1), 0);

    vote_valid = 4'b0101;
    step();
    chk("multi_rej", 32'(rej1), 1);
    chk("multi_ack", 32'(ack1), 0);
    chk("multi_tally", 32'(tally1), 32'(2 << 14));
    step();
    chk("multi_rej_off", 32'(rej1), 0);
    vote_valid = 4'b0;
    step();
    press(0);
    chk("c0_after_multi", c1(0), 1);
    chk("total3", 32'(total1), 3);

    press(1);
    press(1);
    press(1);
    press(2);
    chk("total7", 32'(total1), 7);
    run_scan(4'd1, 1'b1);

    vote_valid = 4'b0001;
    step();
    chk("res_no_ack", 32'(ack1), 0);
    chk("res_no_rej", 32'(rej1), 0);
    chk("res_c0", c1(0), 1);
    chk("res_hold_win", 32'(win1), 1);
    mode = 1'b0;
    step();
    chk("res_exit_rv", 32'(rv1), 0);
    chk("res_exit_ack", 32'(ack1), 0);
    vote_valid = 4'b0;
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) press(2);
    press(3);
    press(3);
    chk("total_b", 32'(total1), 7);
    run_scan(4'd2, 1'b0);
    mode = 1'b0;
    step();
    step();

    mode = 1'b1;
    step();
    step();
    step();
    mode       = 1'b0;
    vote_valid = 4'b0010;
    step();
    chk("abort_rv", 32'(rv1), 0);
    chk("abort_ack", 32'(ack1), 0);
    step();
    chk("abort_locked_ack", 32'(ack1), 0);
    chk("abort_locked_rv", 32'(rv1), 0);
    chk("abort_c1", c1(1), 0);
    vote_valid = 4'b0;
    step();
    press(1);
    chk("abort_c1_after", c1(1), 1);
    chk("total_c", 32'(total1), 8);

    run_scan(4'd2, 1'b0);
    reset = 1'b1;
    step();
    chk("rres_rv", 32'(rv1), 0);
    chk("rres_win", 32'(win1), 0);
    chk("rres_tie", 32'(tie1), 0);
    chk("rres_tally", 32'(tally1), 0);
    chk("rres_total", 32'(total1), 0);
    reset = 1'b0;
    mode  = 1'b0;
    step();

    run_scan(4'd0, 1'b1);
    mode = 1'b0;
    step();
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      vote_valid = 4'b0010;
      step();
      chk("sat_ack", 32'(ack2), (k < 4) ? 1 : 0);
      chk("sat_rej", 32'(rej2), (k < 4) ? 0 : 1);
      chk("sat_flag", 32'(sat2), (k < 4) ? 0 : 1);
      vote_valid = 4'b0;
      step();
    end
    chk("sat_cnt", c2(1), 3);
    chk("sat_total", 32'(total2), 3);
    chk("sat_sticky", 32'(sat2), 1);

    reset      = 1'b1;
    vote_valid = 4'b0001;
    step();
    chk("held_rst_ack", 32'(ack1), 0);
    reset = 1'b0;
    step();
    chk("held_rel_ack", 32'(ack1), 1);
    chk("held_rel_c0", c1(0), 1);
    vote_valid = 4'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
